// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg
//   Shared types and helpers for the VRAM read arbiter and its picker.
//   - arb_state_t : arbiter FSM states (IDLE waits for and grants a request,
//                   BURST issues the remaining words of the granted burst).
//   - rsp_tag_t   : sideband carried through the one-cycle response stage
//                   (valid, owning requester, last-word flag).
//   - eff_len     : effective burst length (a length of 0 means 1 word).
package vram_arb_pkg;

  // Owner field is sized for the largest supported requester count (8).
  localparam int OWNER_W   = 3;
  // eff_len works on a fixed-width container; callers zero-extend into it.
  localparam int LEN_W_MAX = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic               valid;
    logic [OWNER_W-1:0] owner;
    logic               last;
  } rsp_tag_t;

  function automatic logic [LEN_W_MAX-1:0] eff_len(input logic [LEN_W_MAX-1:0] len);
    return (len == '0) ? LEN_W_MAX'(1) : len;
  endfunction

endpackage

// File: rtl/vram_read_arbiter_rr_pick.sv
// rr_pick
//   Combinational rotate-priority finder. Searches req starting at index ptr
//   and walking upward with wrap-around modulo N; reports the first set bit.
//   Ports:
//     req   [N]  request vector
//     ptr   [IW] starting index of the search (must be < N)
//     idx   [IW] index of the winning request (0 when none found)
//     found [1]  at least one request bit was set
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW-1:0] j;

  // Walk the search order backwards so the closest-to-ptr hit is written last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        idx   = j;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vram_read_arbiter.sv
// vram_read_arbiter
//   Shares one VRAM read port between NREQ burst requesters. Grants are
//   round-robin; the granted burst is issued one word per cycle on
//   vram_en/vram_addr and each returned word is tagged to its owner one
//   cycle later (matching the port's registered read latency).
//
//   Handshake: a requester holds req_valid with req_addr/req_len stable until
//   it sees req_ready, a one-cycle pulse; the request is consumed on that
//   cycle and the requester must drop or replace it afterwards. Dropping
//   req_valid before req_ready withdraws the request. Responses have no
//   backpressure: rsp_valid[i] marks a word that requester i must take.
//
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     req_valid  [NREQ]          pending burst request per requester
//     req_addr   [NREQ][AWIDTH]  burst start address
//     req_len    [NREQ][LWIDTH]  burst length (0 means 1)
//     req_ready  [NREQ]          accept pulse to the granted requester
//     rsp_valid  [NREQ]          one-hot owner of the word on rsp_data
//     rsp_last   1               word is the final word of its burst
//     rsp_data   [WIDTH]         returned word (passthrough of vram_data)
//     vram_en, vram_addr         VRAM port request
//     vram_data  [WIDTH]         VRAM port read data (1-cycle latency)
//
//   Build option: define VRAM_ARB_DISPLAY_PRIO_EN to give requester 0
//   (display scan-out) absolute priority in IDLE; its grants leave the
//   round-robin pointer untouched, the others rotate among themselves.
module vram_read_arbiter
  import vram_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 12,
  parameter int AWIDTH = 14,
  parameter int LWIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ-1:0][AWIDTH-1:0]   req_addr,
  input  logic [NREQ-1:0][LWIDTH-1:0]   req_len,
  output logic [NREQ-1:0]               req_ready,
  output logic [NREQ-1:0]               rsp_valid,
  output logic                          rsp_last,
  output logic [WIDTH-1:0]              rsp_data,
  output logic                          vram_en,
  output logic [AWIDTH-1:0]             vram_addr,
  input  logic [WIDTH-1:0]              vram_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t         state, state_d;
  logic [IW-1:0]      rr_ptr, rr_ptr_d;
  logic [IW-1:0]      owner, owner_d;
  logic [AWIDTH-1:0]  next_addr, next_addr_d;
  logic [LWIDTH-1:0]  remaining, remaining_d;
  rsp_tag_t           rsp_q, issue_tag;

  logic [NREQ-1:0]    pick_req;
  logic [IW-1:0]      pick_idx;
  logic               pick_found;

  logic [IW-1:0]      win_idx;
  logic               win_found;
  logic               win_adv;
  logic [LEN_W_MAX-1:0] win_len;

`ifdef VRAM_ARB_DISPLAY_PRIO_EN
  // Requester 0 is handled outside the rotation; the picker only sees 1..N-1.
  assign pick_req = {req_valid[NREQ-1:1], 1'b0};

  always_comb begin
    if (req_valid[0]) begin
      win_idx   = '0;
      win_found = 1'b1;
      win_adv   = 1'b0;
    end else begin
      win_idx   = pick_idx;
      win_found = pick_found;
      win_adv   = 1'b1;
    end
  end
`else
  assign pick_req = req_valid;

  always_comb begin
    win_idx   = pick_idx;
    win_found = pick_found;
    win_adv   = 1'b1;
  end
`endif

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_pick (
    .req   (pick_req),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Next-state, issue and grant logic. Outputs are forced idle while rst is
  // high so nothing is issued or granted during reset.
  always_comb begin
    state_d     = state;
    rr_ptr_d    = rr_ptr;
    owner_d     = owner;
    next_addr_d = next_addr;
    remaining_d = remaining;
    req_ready   = '0;
    vram_en     = 1'b0;
    vram_addr   = '0;
    issue_tag   = '0;
    win_len     = eff_len(LEN_W_MAX'(req_len[win_idx]));

    if (!rst) begin
      case (state)
        IDLE: begin
          if (win_found) begin
            req_ready[win_idx] = 1'b1;
            vram_en            = 1'b1;
            vram_addr          = req_addr[win_idx];
            owner_d            = win_idx;
            next_addr_d        = req_addr[win_idx] + AWIDTH'(1);
            if (win_adv) begin
              rr_ptr_d = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
            end
            issue_tag.valid = 1'b1;
            issue_tag.owner = OWNER_W'(win_idx);
            issue_tag.last  = (win_len == LEN_W_MAX'(1));
            if (win_len != LEN_W_MAX'(1)) begin
              state_d     = BURST;
              remaining_d = LWIDTH'(win_len - LEN_W_MAX'(1));
            end
          end
        end

        BURST: begin
          vram_en         = 1'b1;
          vram_addr       = next_addr;
          next_addr_d     = next_addr + AWIDTH'(1);
          remaining_d     = remaining - LWIDTH'(1);
          issue_tag.valid = 1'b1;
          issue_tag.owner = OWNER_W'(owner);
          issue_tag.last  = (remaining == LWIDTH'(1));
          if (remaining == LWIDTH'(1)) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      next_addr <= '0;
      remaining <= '0;
      rsp_q     <= '0;
    end else begin
      state     <= state_d;
      rr_ptr    <= rr_ptr_d;
      owner     <= owner_d;
      next_addr <= next_addr_d;
      remaining <= remaining_d;
      // The tag lines up with the word the VRAM returns on the next cycle.
      rsp_q     <= issue_tag;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = rsp_q.valid && (rsp_q.owner == OWNER_W'(i));
    end
  end

  assign rsp_last = rsp_q.valid & rsp_q.last;
  assign rsp_data = vram_data;

endmodule

// File: tb/tb_vram_read_arbiter.sv
module tb_vram_read_arbiter;

  localparam int NREQ   = 4;
  localparam int WIDTH  = 12;
  localparam int AWIDTH = 14;
  localparam int LWIDTH = 4;
  localparam int IW_W   = NREQ + AWIDTH;
  localparam int RW_W   = NREQ + 1 + WIDTH;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic [NREQ-1:0]             req_valid = '0;
  logic [NREQ-1:0][AWIDTH-1:0] req_addr = '0;
  logic [NREQ-1:0][LWIDTH-1:0] req_len = '0;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0]             rsp_valid;
  logic                        rsp_last;
  logic [WIDTH-1:0]            rsp_data;
  logic                        vram_en;
  logic [AWIDTH-1:0]           vram_addr;
  logic [WIDTH-1:0]            vram_data = '0;

  logic [IW_W-1:0] exp_iss_q[$];
  logic [RW_W-1:0] exp_rsp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  vram_read_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_last  (rsp_last),
    .rsp_data  (rsp_data),
    .vram_en   (vram_en),
    .vram_addr (vram_addr),
    .vram_data (vram_data)
  );

  // ---------------- clock / VRAM model ----------------
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] mem(input logic [AWIDTH-1:0] a);
    return a[11:0] ^ {a[13:12], a[13:12], 8'hA5};
  endfunction

  always @(posedge clk) vram_data <= vram_en ? mem(vram_addr) : '0;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic push_issue(input logic [NREQ-1:0] rdy, input logic [AWIDTH-1:0] a);
    exp_iss_q.push_back({rdy, a});
  endtask

  task automatic push_rsp(input logic [NREQ-1:0] own, input logic last, input logic [AWIDTH-1:0] a);
    exp_rsp_q.push_back({own, last, mem(a)});
  endtask

  // Expected issues and responses of a whole burst of n words.
  task automatic push_burst(input int i, input logic [AWIDTH-1:0] a, input int n);
    logic [NREQ-1:0] own;
    own = NREQ'(1 << i);
    for (int k = 0; k < n; k++) begin
      push_issue((k == 0) ? own : '0, AWIDTH'(a + k));
      push_rsp(own, k == n - 1, AWIDTH'(a + k));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int i);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (req_ready[i]) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout req%0d got no req_ready within 200 cycles, required a grant", i);
    end
  endtask

  // Present one request, hold it until accepted, then scramble the fields
  // so any late sampling of addr/len would show up.
  task automatic request(input int i, input logic [AWIDTH-1:0] a, input logic [LWIDTH-1:0] l);
    @(posedge clk); #1;
    req_addr[i]  = a;
    req_len[i]   = l;
    req_valid[i] = 1'b1;
    wait_ready(i);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    req_addr[i]  = 14'h2AAA;
    req_len[i]   = 4'hF;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h required %h", name, got, want);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [IW_W-1:0] ei;
    logic [RW_W-1:0] er;
    if (!rst) begin
      if (vram_en) begin
        n_cmp++;
        if (exp_iss_q.size() == 0) begin
          n_fail++;
          $display("FAIL issue_unexpected got ready=%b addr=%h required no issue", req_ready, vram_addr);
        end else begin
          ei = exp_iss_q.pop_front();
          if ({req_ready, vram_addr} !== ei) begin
            n_fail++;
            $display("FAIL issue got ready=%b addr=%h required ready=%b addr=%h",
                     req_ready, vram_addr, ei[IW_W-1:AWIDTH], ei[AWIDTH-1:0]);
          end
        end
      end else if (req_ready != '0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL ready_without_en got ready=%b required 0000", req_ready);
      end

      if (rsp_valid != '0) begin
        n_cmp++;
        if (exp_rsp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected got valid=%b last=%b data=%h required no response",
                   rsp_valid, rsp_last, rsp_data);
        end else begin
          er = exp_rsp_q.pop_front();
          if ({rsp_valid, rsp_last, rsp_data} !== er) begin
            n_fail++;
            $display("FAIL rsp got valid=%b last=%b data=%h required valid=%b last=%b data=%h",
                     rsp_valid, rsp_last, rsp_data,
                     er[RW_W-1:WIDTH+1], er[WIDTH], er[WIDTH-1:0]);
          end
        end
      end else if (rsp_last) begin
        n_cmp++;
        n_fail++;
        $display("FAIL last_without_valid got rsp_last=1 required 0");
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt;

    // Reset state, with requests pending to prove nothing leaks out.
    req_valid = '1;
    req_addr  = {14'h0333, 14'h0222, 14'h0111, 14'h0055};
    repeat (2) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'h0);
    check("reset_vram_en",   32'(vram_en),   32'h0);
    check("reset_vram_addr", 32'(vram_addr), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_last",  32'(rsp_last),  32'h0);
    req_valid = '0;
    req_addr  = '0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Contention: two rounds of all four, single-word bursts.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NREQ; i++) push_burst(i, AWIDTH'(14'h0100 * (i + 1) + r), 1);
      fork
        request(0, AWIDTH'(14'h0100 + r), 4'd1);
        request(1, AWIDTH'(14'h0200 + r), 4'd1);
        request(2, AWIDTH'(14'h0300 + r), 4'd1);
        request(3, AWIDTH'(14'h0400 + r), 4'd1);
      join
      repeat (3) @(posedge clk);
    end

    // Single request, len=3.
    push_burst(0, 14'h0010, 3);
    request(0, 14'h0010, 4'd3);
    repeat (5) @(posedge clk);

    // len=0 at the top address, then a wrapping len=2 burst.
    push_burst(2, 14'h3FFF, 1);
    request(2, 14'h3FFF, 4'd0);
    repeat (3) @(posedge clk);
    push_issue(4'b0100, 14'h3FFF);
    push_rsp(4'b0100, 1'b0, 14'h3FFF);
    push_issue(4'b0000, 14'h0000);
    push_rsp(4'b0100, 1'b1, 14'h0000);
    request(2, 14'h3FFF, 4'd2);
    repeat (4) @(posedge clk);

    // Burst blocking: req3 arrives mid-way through a 15-word burst.
    push_burst(1, 14'h0500, 15);
    push_burst(3, 14'h0600, 1);
    fork
      request(1, 14'h0500, 4'd15);
      begin
        repeat (5) @(posedge clk);
        request(3, 14'h0600, 4'd1);
      end
      begin
        wait_ready(1);
        cnt = 1;
        for (int k = 0; k < 15; k++) begin
          @(negedge clk);
          if (vram_en) cnt++;
        end
        check("burst_no_gap_en_cycles", 32'(cnt), 32'd16);
      end
    join
    repeat (4) @(posedge clk);

    // Reset during the second word of a len=5 burst.
    push_issue(4'b0001, 14'h0040);
    push_issue(4'b0000, 14'h0041);
    push_rsp(4'b0001, 1'b0, 14'h0040);
    @(posedge clk); #1;
    req_addr[0]  = 14'h0040;
    req_len[0]   = 4'd5;
    req_valid[0] = 1'b1;
    wait_ready(0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("midreset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("midreset_rsp_last",  32'(rsp_last),  32'h0);
    check("midreset_vram_en",   32'(vram_en),   32'h0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);

    // After reset the arbiter must be back in IDLE: a fresh single-word
    // request is granted and served normally.
    push_burst(3, 14'h0777, 1);
    request(3, 14'h0777, 4'd1);
    repeat (3) @(posedge clk);

`ifdef VRAM_ARB_DISPLAY_PRIO_EN
    // Requester 0 keeps winning while valid; requester 2 waits.
    for (int k = 0; k < 4; k++) push_burst(0, 14'h0300, 1);
    push_burst(2, 14'h0310, 1);
    @(posedge clk); #1;
    req_addr[0] = 14'h0300; req_len[0] = 4'd1; req_valid[0] = 1'b1;
    req_addr[2] = 14'h0310; req_len[2] = 4'd1; req_valid[2] = 1'b1;
    for (int k = 0; k < 4; k++) wait_ready(0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_ready(2);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    repeat (3) @(posedge clk);
`endif

    repeat (5) @(negedge clk);
    check("issue_queue_drained", 32'(exp_iss_q.size()), 32'd0);
    check("rsp_queue_drained",   32'(exp_rsp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
